mem_stage_access_unit: RTL and testbench

- Consumer end of the EX/MEM pipeline register (the MEM stage); reads the EX/MEM outputs.
- Runs loads and stores against a req/ack data-memory port and resolves branches (PCSrc).
- Stalls the front of the pipe while a memory transaction is outstanding.
- Presents the MEM/WB-bound bundle, including aligned and sign-extended load data.

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_stage_access_unit_lane_align.sv | 24 ++
 rtl/mem_stage_access_unit.sv | 112 +++++++++++
 tb/tb_mem_stage_access_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: size encodings, FSM states and byte-enable constants for the MEM stage
package mem_stage_pkg;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b11;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO = 4'b0011;
  localparam logic [3:0] BE_HI = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
endpackage

// File: rtl/mem_stage_access_unit_lane_align.sv
// mem_lane_align: byte enables, replicated store data and sign-extended load extract
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [15:0] h;
  logic [7:0]  b;
  // lane select by low address bits, little-endian
  always_comb begin
    h = addr[1] ? rd[31:16] : rd[15:0];
    b = addr[0] ? h[15:8] : h[7:0];
    be = size == MEM_WORD ? BE_WORD : size == MEM_HALF ? (addr[1] ? BE_HI : BE_LO) :
         size == MEM_BYTE ? BE_B0 << addr : 4'h0;
    wdata = size == MEM_HALF ? {2{wd[15:0]}} : size == MEM_BYTE ? {4{wd[7:0]}} : wd;
    rdata = size == MEM_HALF ? {{16{h[15]}}, h} : size == MEM_BYTE ? {{24{b[7]}}, b} : rd;
  end
endmodule

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM stage load/store over req/ack port with branch resolve (option MEM_ALIGN_CHECK_EN)
module mem_stage_access_unit
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int WAIT_CNT_W = 7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic [31:0] PCAddResultIn,
  input  logic [1:0]  MemWriteIn,
  input  logic [1:0]  MemReadIn,
  input  logic        BranchIn,
  input  logic        ZeroIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  input  logic [31:0] WriteRegisterIn,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        StallOut,
  output logic        PCSrcOut,
  output logic [31:0] BranchTargetOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] WriteRegisterOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic        ErrorOut
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        MisalignOut
`endif
);
  state_t state, next;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [31:0] addr_q, data_q, wdata, rdata;
  logic [1:0] size_q, size_in;
  logic [3:0] be;
  logic we_q, err_q, mis_q, op, misalign, timeout, in_req, start;
  assign op = (MemWriteIn != MEM_NONE) || (MemReadIn != MEM_NONE);
  assign size_in = MemWriteIn != MEM_NONE ? MemWriteIn : MemReadIn;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (size_in == MEM_WORD && ALUResultIn[1:0] != 2'b00) || (size_in == MEM_HALF && ALUResultIn[0]);
  assign MisalignOut = mis_q;
`else
  assign misalign = 1'b0;
`endif
  assign in_req = state == ST_REQ;
  assign start = state == ST_IDLE && op;
  assign timeout = in_req && !MemAck && cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
  mem_lane_align u_align (
    .size(size_q),
    .addr(addr_q[1:0]),
    .wd(data_q),
    .rd(MemRData),
    .be(be),
    .wdata(wdata),
    .rdata(rdata)
  );
  // next-state: misaligned accesses skip the request phase
  always_comb begin
    next = state == ST_IDLE ? (op ? (misalign ? ST_DONE : ST_REQ) : ST_IDLE) :
           in_req ? (MemAck || timeout ? ST_DONE : ST_REQ) : ST_IDLE;
  end
  // state, latched transaction, wait counter and load result
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= MEM_NONE;
      we_q <= 1'b0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
      ReadDataOut <= '0;
    end else begin
      state <= next;
      cnt <= in_req ? cnt + WAIT_CNT_W'(1) : '0;
      err_q <= timeout;
      mis_q <= start && misalign;
      if (start) begin
        addr_q <= ALUResultIn;
        data_q <= ReadData2In;
        size_q <= size_in;
        we_q <= MemWriteIn != MEM_NONE;
      end
      if (in_req && MemAck) ReadDataOut <= rdata;
      else if (timeout || (start && misalign)) ReadDataOut <= '0;
    end
  end
  assign MemReq = in_req;
  assign MemWe = in_req && we_q;
  assign MemAddr = {addr_q[31:2], 2'b00};
  assign MemWData = wdata;
  assign MemByteEn = in_req ? be : 4'h0;
  assign StallOut = in_req || start;
  assign PCSrcOut = BranchIn && ZeroIn && !StallOut && !Reset;
  assign BranchTargetOut = PCAddResultIn;
  assign ALUResultOut = ALUResultIn;
  assign WriteRegisterOut = WriteRegisterIn;
  assign MemToRegOut = MemToRegIn;
  assign RegWriteOut = RegWriteIn && !err_q && !mis_q;
  assign ErrorOut = err_q;
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb_mem_stage_access_unit: directed vectors checked against a per-instruction timing model
module tb_mem_stage_access_unit;
  localparam int TO = 64;
  logic Clock = 0, Reset = 1;
  logic [31:0] ALUResultIn = 0, ReadData2In = 0, PCAddResultIn = 0, WriteRegisterIn = 0, MemRData = 0;
  logic [1:0] MemWriteIn = 0, MemReadIn = 0;
  logic BranchIn = 0, ZeroIn = 0, RegWriteIn = 0, MemToRegIn = 0, MemAck = 0;
  logic MemReq, MemWe, StallOut, PCSrcOut, RegWriteOut, MemToRegOut, ErrorOut;
  logic [31:0] MemAddr, MemWData, BranchTargetOut, ReadDataOut, ALUResultOut, WriteRegisterOut;
  logic [3:0] MemByteEn;
`ifdef MEM_ALIGN_CHECK_EN
  logic MisalignOut;
  logic e_mis = 0;
`endif
  int checks = 0, errors = 0;
  logic chk_en = 0, chk_bus = 0, chk_rd = 0;
  logic e_req, e_we, e_stall, e_pcsrc, e_err, e_rw;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [3:0] e_be;

  mem_stage_access_unit dut (
    .Clock(Clock), .Reset(Reset), .ALUResultIn(ALUResultIn), .ReadData2In(ReadData2In),
    .PCAddResultIn(PCAddResultIn), .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn),
    .BranchIn(BranchIn), .ZeroIn(ZeroIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .WriteRegisterIn(WriteRegisterIn), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemByteEn(MemByteEn), .MemRData(MemRData), .MemAck(MemAck),
    .StallOut(StallOut), .PCSrcOut(PCSrcOut), .BranchTargetOut(BranchTargetOut),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut), .WriteRegisterOut(WriteRegisterOut),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .ErrorOut(ErrorOut)
`ifdef MEM_ALIGN_CHECK_EN
    , .MisalignOut(MisalignOut)
`endif
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 1) return 4'hF;
    if (sz == 2) return (a % 4) >= 2 ? 4'hC : 4'h3;
    if (sz == 3) return 4'(1 << (a % 4));
    return 4'h0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    if (sz == 3) return (d & 32'hFF) * 32'h01010101;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] r);
    longint v;
    if (sz == 2) begin
      v = (r >> (16 * ((a % 4) / 2))) & 'hFFFF;
      if (v >= 32768) v -= 65536;
      return 32'(v);
    end
    if (sz == 3) begin
      v = (r >> (8 * (a % 4))) & 'hFF;
      if (v >= 128) v -= 256;
      return 32'(v);
    end
    return r;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (sz == 1 && a % 4 != 0) || (sz == 2 && a % 2 != 0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge Clock) if (chk_en) begin
    chk("StallOut", StallOut, e_stall);
    chk("MemReq", MemReq, e_req);
    chk("MemWe", MemWe, e_we);
    chk("MemByteEn", MemByteEn, e_be);
    chk("PCSrcOut", PCSrcOut, e_pcsrc);
    chk("ErrorOut", ErrorOut, e_err);
    chk("RegWriteOut", RegWriteOut, e_rw);
    chk("MemToRegOut", MemToRegOut, MemToRegIn);
    chk("ALUResultOut", ALUResultOut, ALUResultIn);
    chk("WriteRegisterOut", WriteRegisterOut, WriteRegisterIn);
    chk("BranchTargetOut", BranchTargetOut, PCAddResultIn);
`ifdef MEM_ALIGN_CHECK_EN
    chk("MisalignOut", MisalignOut, e_mis);
`endif
    if (chk_bus) begin
      chk("MemAddr", MemAddr, e_addr);
      chk("MemWData", MemWData, e_wdata);
    end
    if (chk_rd) chk("ReadDataOut", ReadDataOut, e_rd);
  end

  // one instruction held on the EX/MEM inputs until the model says it retires; ack_at=0 means never acked
  task automatic run_op(input logic [1:0] wr, input logic [1:0] rs, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat, input int ack_at,
                        input logic br, input logic z, input logic rw);
    logic [1:0] sz;
    logic isw, op, mis, to, done;
    int last, n;
    sz = wr != 0 ? wr : rs;
    isw = wr != 0;
    op = sz != 0;
    mis = op && m_misaligned(sz, addr);
    to = op && !mis && ack_at == 0;
    last = mis ? 0 : to ? TO : ack_at;
    n = !op ? 1 : last + 2;
    MemWriteIn = wr; MemReadIn = rs; ALUResultIn = addr; ReadData2In = wd;
    PCAddResultIn = addr + 32'h1000; WriteRegisterIn = addr ^ 32'h5;
    BranchIn = br; ZeroIn = z; RegWriteIn = rw; MemToRegIn = rs != 0; MemRData = rdat;
    chk_en = 1;
    for (int c = 0; c < n; c++) begin
      done = op && c == n - 1;
      MemAck = op ? (!mis && ack_at != 0 && c == ack_at) : (ack_at != 0);
      e_stall = op && c <= last;
      e_req = op && !mis && c >= 1 && c <= last;
      e_we = e_req && isw;
      e_be = e_req ? m_be(sz, addr) : 4'h0;
      e_addr = addr & 32'hFFFFFFFC;
      e_wdata = m_wdata(sz, wd);
      chk_bus = e_req;
      e_pcsrc = br && z && !e_stall;
      e_err = done && to;
      e_rw = rw && !(done && (to || mis));
`ifdef MEM_ALIGN_CHECK_EN
      e_mis = done && mis;
`endif
      chk_rd = done && (!isw || to || mis);
      e_rd = (to || mis) ? 32'h0 : m_load(sz, addr, rdat);
      @(posedge Clock); #1;
    end
    MemAck = 0;
    chk_bus = 0;
    chk_rd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("model_be_byte", m_be(3, 32'h103), 32'h8);
    chk("model_wdata_byte", m_wdata(3, 32'hA5), 32'hA5A5A5A5);
    chk("model_load_half", m_load(2, 32'h202, 32'h80011234), 32'hFFFF8001);
    chk("model_load_byte", m_load(3, 32'h201, 32'h00007F00), 32'h0000007F);
    BranchIn = 1; ZeroIn = 1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("rst_MemReq", MemReq, 0);
    chk("rst_MemWe", MemWe, 0);
    chk("rst_ErrorOut", ErrorOut, 0);
    chk("rst_PCSrcOut", PCSrcOut, 0);
    chk("rst_MemByteEn", MemByteEn, 0);
    chk("rst_ReadDataOut", ReadDataOut, 0);
    chk("rst_StallOut", StallOut, 0);
    @(posedge Clock); #1;
    Reset = 0;
    run_op(0, 0, 32'h40 - 32'h1000, 0, 0, 0, 1, 1, 1);
    chk("branch_target_literal", PCAddResultIn, 32'h40);
    run_op(0, 1, 32'h100, 0, 32'hDEADBEEF, 3, 1, 1, 1);
    run_op(3, 0, 32'h103, 32'h000000A5, 0, 1, 0, 0, 0);
    run_op(0, 2, 32'h202, 0, 32'h80011234, 2, 0, 0, 1);
    run_op(0, 3, 32'h201, 0, 32'h00007F00, 1, 1, 0, 1);
    run_op(0, 2, 32'h200, 0, 32'hABCD7FFE, 1, 0, 1, 1);
    run_op(0, 3, 32'h203, 0, 32'h80FFFFFF, 4, 0, 0, 1);
    run_op(0, 3, 32'h202, 0, 32'h12345678, 2, 0, 0, 1);
    run_op(2, 1, 32'h206, 32'h1234BEEF, 32'hFFFFFFFF, 2, 0, 0, 0);
    run_op(1, 0, 32'h300, 32'hCAFEF00D, 0, 0, 0, 0, 1);
    MemRData = 32'hFFFFFFFF;
    run_op(0, 0, 32'h500, 0, 32'hFFFFFFFF, 1, 0, 0, 1);
    @(negedge Clock);
    chk("idle_ack_ignored", ReadDataOut, 0);
    @(posedge Clock); #1;
    run_op(0, 1, 32'h104, 0, 32'h55AA55AA, 0, 0, 0, 1);
    chk_en = 0;
    MemReadIn = 2'b01; ALUResultIn = 32'h400;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset = 1;
    @(negedge Clock);
    chk("rst_mid_req_before", MemReq, 1);
    @(posedge Clock); #1;
    Reset = 0; MemReadIn = 0; MemWriteIn = 0; MemAck = 1; MemRData = 32'h12345678;
    @(negedge Clock);
    chk("rst_mid_MemReq", MemReq, 0);
    chk("rst_mid_StallOut", StallOut, 0);
    @(posedge Clock); #1;
    MemAck = 0;
    @(negedge Clock);
    chk("rst_late_ack_ignored", ReadDataOut, 0);
    chk("rst_late_MemReq", MemReq, 0);
    @(posedge Clock); #1;
    run_op(0, 1, 32'h108, 0, 32'h0BADF00D, 1, 0, 0, 1);
`ifdef MEM_ALIGN_CHECK_EN
    run_op(0, 1, 32'h102, 0, 32'h11111111, 1, 0, 0, 1);
    run_op(2, 0, 32'h101, 32'h1234, 0, 1, 0, 0, 1);
`endif
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
